cr_clic_arb: RTL and testbench

- Downstream consumer of the per-interrupt CLIC kid outputs (kid_arb_int_req, kid_arb_int_all, kid_arb_int_hv).
- Selects the highest-priority pending interrupt that is above the threshold, using a 2-stage registered tournament.
- Presents the winner to the core over a valid/ack handshake.
- On ack, returns a one-hot claim pulse to the winning kid and blanks its output until the pipeline has refilled.

---
 rtl/cr_clic_arb_pkg.sv | 25 ++
 rtl/cr_clic_arb_grp.sv | 47 ++++
 rtl/cr_clic_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_cr_clic_arb.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_clic_arb_pkg.sv
// Shared constants, FSM encoding and small helpers for the CLIC arbiter.
package cr_clic_arb_pkg;

  localparam int CLIC_INTCTLBITS = 3;
  localparam int ARB_PRIO_W      = CLIC_INTCTLBITS + 1;
  localparam int ARB_INT_NUM     = 64;
  localparam int ARB_GROUP       = 8;
  localparam int ARB_ID_W        = $clog2(ARB_INT_NUM);

  // Cycles the output stays quiet after a claim or flush, giving the
  // claimed kid time to drop its pending bit.
  localparam logic [1:0] BLANK_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VALID = 2'b01,
    ST_BLANK = 2'b10
  } arb_state_e;

  // Index width for an n-entry reduction, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_clic_arb_grp.sv
// Combinational max-priority reduction over N entries; on equal priority
// the lowest index wins.
module cr_clic_arb_grp
  import cr_clic_arb_pkg::*;
#(
  parameter int N      = 8,
  parameter int PRIO_W = 4,
  parameter int IDX_W  = idx_w(N)
) (
  input  logic [N-1:0]        vld_i,
  input  logic [N*PRIO_W-1:0] prio_i,
  input  logic [N-1:0]        hv_i,
  output logic                vld_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic [PRIO_W-1:0]   prio_o,
  output logic                hv_o
);

  logic              best_vld_s;
  logic [IDX_W-1:0]  best_idx_s;
  logic [PRIO_W-1:0] best_prio_s;
  logic              best_hv_s;

  // Linear scan; a strict greater-than keeps the earlier entry on a tie.
  always_comb begin
    best_vld_s  = 1'b0;
    best_idx_s  = '0;
    best_prio_s = '0;
    best_hv_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vld_i[i] && (!best_vld_s || (prio_i[i*PRIO_W +: PRIO_W] > best_prio_s))) begin
        best_vld_s  = 1'b1;
        best_idx_s  = IDX_W'(i);
        best_prio_s = prio_i[i*PRIO_W +: PRIO_W];
        best_hv_s   = hv_i[i];
      end else begin
        best_vld_s  = best_vld_s;
      end
    end
  end

  assign vld_o  = best_vld_s;
  assign idx_o  = best_idx_s;
  assign prio_o = best_prio_s;
  assign hv_o   = best_hv_s;

endmodule

// File: rtl/cr_clic_arb.sv
// CLIC arbiter: qualifies kid requests against the threshold, picks the
// winner through a two-stage registered tournament and presents it to the
// core with a valid/ack handshake and a one-hot claim back to the kid.
module cr_clic_arb
  import cr_clic_arb_pkg::*;
#(
  parameter int INT_NUM = ARB_INT_NUM,
  parameter int PRIO_W  = ARB_PRIO_W,
  parameter int GROUP   = ARB_GROUP,
  parameter int ID_W    = ARB_ID_W
) (
  input  logic                        clic_clk,
  input  logic                        clic_rst,
  input  logic [INT_NUM-1:0]          kid_arb_int_req,
  input  logic [INT_NUM*PRIO_W-1:0]   kid_arb_int_all,
  input  logic [INT_NUM-1:0]          kid_arb_int_hv,
  input  logic [PRIO_W-1:0]           ctrl_arb_thresh,
  input  logic                        ctrl_arb_flush,
  input  logic                        cpu_arb_int_ack,
  output logic                        arb_cpu_int_vld,
  output logic [ID_W-1:0]             arb_cpu_int_id,
  output logic [PRIO_W-1:0]           arb_cpu_int_prio,
  output logic                        arb_cpu_int_hv,
  output logic [INT_NUM-1:0]          arb_kid_int_claim
);

  localparam int NGRP   = INT_NUM / GROUP;
  localparam int GID_W  = idx_w(GROUP);
  localparam int GSEL_W = idx_w(NGRP);

  // ---------------- qualification ----------------
  logic [INT_NUM-1:0] qual_s;

  for (genvar gi = 0; gi < INT_NUM; gi++) begin : g_qual
    assign qual_s[gi] = kid_arb_int_req[gi] &
                        (kid_arb_int_all[gi*PRIO_W +: PRIO_W] > ctrl_arb_thresh);
  end

  // ---------------- stage 1: per-group winners ----------------
  logic [NGRP-1:0]        s1_vld_d,  s1_vld_q;
  logic [NGRP*GID_W-1:0]  s1_idx_d,  s1_idx_q;
  logic [NGRP*PRIO_W-1:0] s1_prio_d, s1_prio_q;
  logic [NGRP-1:0]        s1_hv_d,   s1_hv_q;

  for (genvar gg = 0; gg < NGRP; gg++) begin : g_s1
    cr_clic_arb_grp #(
      .N      (GROUP),
      .PRIO_W (PRIO_W),
      .IDX_W  (GID_W)
    ) u_grp (
      .vld_i  (qual_s[gg*GROUP +: GROUP]),
      .prio_i (kid_arb_int_all[gg*GROUP*PRIO_W +: GROUP*PRIO_W]),
      .hv_i   (kid_arb_int_hv[gg*GROUP +: GROUP]),
      .vld_o  (s1_vld_d[gg]),
      .idx_o  (s1_idx_d[gg*GID_W +: GID_W]),
      .prio_o (s1_prio_d[gg*PRIO_W +: PRIO_W]),
      .hv_o   (s1_hv_d[gg])
    );
  end

  // Stage-1 register; flush empties it.
  always_ff @(posedge clic_clk or posedge clic_rst) begin
    if (clic_rst) begin
      s1_vld_q  <= '0;
      s1_idx_q  <= '0;
      s1_prio_q <= '0;
      s1_hv_q   <= '0;
    end else if (ctrl_arb_flush) begin
      s1_vld_q  <= '0;
      s1_idx_q  <= '0;
      s1_prio_q <= '0;
      s1_hv_q   <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_idx_q  <= s1_idx_d;
      s1_prio_q <= s1_prio_d;
      s1_hv_q   <= s1_hv_d;
    end
  end

  // ---------------- stage 2: winner across groups ----------------
  logic              w_vld_s;
  logic [GSEL_W-1:0] w_grp_s;
  logic [PRIO_W-1:0] w_prio_s;
  logic              w_hv_s;
  logic [GID_W-1:0]  w_gid_s;
  logic [ID_W-1:0]   s2_id_d;

  cr_clic_arb_grp #(
    .N      (NGRP),
    .PRIO_W (PRIO_W),
    .IDX_W  (GSEL_W)
  ) u_s2 (
    .vld_i  (s1_vld_q),
    .prio_i (s1_prio_q),
    .hv_i   (s1_hv_q),
    .vld_o  (w_vld_s),
    .idx_o  (w_grp_s),
    .prio_o (w_prio_s),
    .hv_o   (w_hv_s)
  );

  assign w_gid_s = s1_idx_q[w_grp_s*GID_W +: GID_W];
  assign s2_id_d = ID_W'(w_grp_s) * ID_W'(GROUP) + ID_W'(w_gid_s);

  logic              s2_vld_q;
  logic [ID_W-1:0]   s2_id_q;
  logic [PRIO_W-1:0] s2_prio_q;
  logic              s2_hv_q;

  // Stage-2 register; the payload keeps the last valid winner so a
  // presented-but-stale cycle never shows a meaningless id.
  always_ff @(posedge clic_clk or posedge clic_rst) begin
    if (clic_rst) begin
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_prio_q <= '0;
      s2_hv_q   <= 1'b0;
    end else if (ctrl_arb_flush) begin
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_prio_q <= '0;
      s2_hv_q   <= 1'b0;
    end else begin
      s2_vld_q <= w_vld_s;
      if (w_vld_s) begin
        s2_id_q   <= s2_id_d;
        s2_prio_q <= w_prio_s;
        s2_hv_q   <= w_hv_s;
      end
    end
  end

  // ---------------- presentation FSM ----------------
  arb_state_e         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [INT_NUM-1:0] claim_q, claim_d;
  logic [ID_W-1:0]    last_id_q;
  logic [PRIO_W-1:0]  last_prio_q;
  logic               last_hv_q;

  // State, blank counter and claim pulse registers.
  always_ff @(posedge clic_clk or posedge clic_rst) begin
    if (clic_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      claim_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      claim_q <= claim_d;
    end
  end

  // Next state; flush overrides everything, including a same-cycle ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    claim_d = '0;
    if (ctrl_arb_flush) begin
      state_d = ST_BLANK;
      cnt_d   = BLANK_DEPTH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s2_vld_q && (cnt_q == 2'd0)) begin
            state_d = ST_VALID;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_VALID: begin
          if (cpu_arb_int_ack) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_DEPTH;
            claim_d = {{(INT_NUM-1){1'b0}}, 1'b1} << s2_id_q;
          end else if (!s2_vld_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_VALID;
          end
        end
        ST_BLANK: begin
          if (cnt_q <= 2'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d   = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Remember what was last presented so the outputs hold while vld is low.
  always_ff @(posedge clic_clk or posedge clic_rst) begin
    if (clic_rst) begin
      last_id_q   <= '0;
      last_prio_q <= '0;
      last_hv_q   <= 1'b0;
    end else if (state_q == ST_VALID) begin
      last_id_q   <= s2_id_q;
      last_prio_q <= s2_prio_q;
      last_hv_q   <= s2_hv_q;
    end
  end

  // Outputs: live stage-2 winner while valid, held values otherwise.
  always_comb begin
    arb_cpu_int_vld = (state_q == ST_VALID);
    if (state_q == ST_VALID) begin
      arb_cpu_int_id   = s2_id_q;
      arb_cpu_int_prio = s2_prio_q;
      arb_cpu_int_hv   = s2_hv_q;
    end else begin
      arb_cpu_int_id   = last_id_q;
      arb_cpu_int_prio = last_prio_q;
      arb_cpu_int_hv   = last_hv_q;
    end
  end

  assign arb_kid_int_claim = claim_q;

endmodule

// File: tb/tb_cr_clic_arb.sv
// Self-checking bench for cr_clic_arb: directed table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_cr_clic_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  req;
  logic [255:0] all;
  logic [63:0]  hv;
  logic [3:0]   thresh;
  logic         flush;
  logic         ack;
  logic         vld;
  logic [5:0]   id;
  logic [3:0]   prio;
  logic         ohv;
  logic [63:0]  claim;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cr_clic_arb dut (
    .clic_clk          (clk),
    .clic_rst          (rst),
    .kid_arb_int_req   (req),
    .kid_arb_int_all   (all),
    .kid_arb_int_hv    (hv),
    .ctrl_arb_thresh   (thresh),
    .ctrl_arb_flush    (flush),
    .cpu_arb_int_ack   (ack),
    .arb_cpu_int_vld   (vld),
    .arb_cpu_int_id    (id),
    .arb_cpu_int_prio  (prio),
    .arb_cpu_int_hv    (ohv),
    .arb_kid_int_claim (claim)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; int id; int pr; bit hv; } win_t;

  win_t        m_p1, m_p2, m_good;
  int          m_mode;   // 0 quiet-idle, 1 presenting, 2 blanking
  int          m_q;
  logic [63:0] m_claim;
  int          sh_id, sh_pr;
  bit          sh_hv;

  function automatic win_t empty_win();
    win_t w;
    w.v = 1'b0; w.id = 0; w.pr = 0; w.hv = 1'b0;
    return w;
  endfunction

  // Best qualifying kid right now: highest priority, lowest index on ties.
  function automatic win_t pick();
    win_t w;
    int p;
    w = empty_win();
    for (int i = 0; i < 64; i++) begin
      p = int'(all[i*4 +: 4]);
      if (req[i] && p > int'(thresh) && p > w.pr) begin
        w.v = 1'b1; w.id = i; w.pr = p; w.hv = hv[i];
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_p1 = empty_win(); m_p2 = empty_win(); m_good = empty_win();
    m_mode = 0; m_q = 0; m_claim = '0;
    sh_id = 0; sh_pr = 0; sh_hv = 1'b0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    win_t pres;
    logic [63:0] one;
    one = 64'd1;
    pres = m_p2.v ? m_p2 : m_good;
    m_claim = '0;
    if (flush) begin
      m_mode = 2; m_q = 2;
    end else if (m_mode == 1) begin
      if (ack) begin
        m_claim = one << pres.id;
        m_mode = 2; m_q = 2;
      end else if (!m_p2.v) begin
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      m_q = m_q - 1;
      if (m_q == 0) m_mode = 0;
    end else begin
      if (m_p2.v) m_mode = 1;
    end
    if (flush) begin
      m_p1 = empty_win(); m_p2 = empty_win(); m_good = empty_win();
    end else begin
      m_p2 = m_p1;
      if (m_p2.v) m_good = m_p2;
      m_p1 = pick();
    end
  endtask

  task automatic check_model();
    win_t pres;
    pres = m_p2.v ? m_p2 : m_good;
    if (m_mode == 1) begin
      sh_id = pres.id; sh_pr = pres.pr; sh_hv = pres.hv;
    end
    chk("model_vld",   64'(vld),   64'(m_mode == 1));
    chk("model_id",    64'(id),    64'(sh_id));
    chk("model_prio",  64'(prio),  64'(sh_pr));
    chk("model_hv",    64'(ohv),   64'(sh_hv));
    chk("model_claim", claim,      m_claim);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_kid(input int k, input int p, input bit h);
    req[k] = 1'b1;
    all[k*4 +: 4] = 4'(p);
    hv[k] = h;
  endtask

  task automatic clear_kids();
    req = '0;
    for (int i = 0; i < 64; i++) all[i*4 +: 4] = 4'($urandom_range(15, 0));
    hv = {$urandom, $urandom};
  endtask

  task automatic wait_vld(input string nm, input int lim);
    bit got;
    got = 1'b0;
    for (int t = 0; t < lim && !got; t++) begin
      tick();
      if (vld === 1'b1) got = 1'b1;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int k0; int p0; bit h0;
    int k1; int p1; bit h1;
    int th;
    bit ev; int eid; int epr; bit ehv;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] one;
    one = 64'd1;

    tbl[0] = '{12, 7, 1'b1, -1, 0, 1'b0,  0, 1'b1, 12,  7, 1'b1};
    tbl[1] = '{ 9, 5, 1'b0,  3, 5, 1'b0,  0, 1'b1,  3,  5, 1'b0};
    tbl[2] = '{ 3, 5, 1'b0, 40, 9, 1'b0,  0, 1'b1, 40,  9, 1'b0};
    tbl[3] = '{ 7, 4, 1'b1, -1, 0, 1'b0,  4, 1'b0, 40,  9, 1'b0};
    tbl[4] = '{ 7, 4, 1'b1, -1, 0, 1'b0,  3, 1'b1,  7,  4, 1'b1};
    tbl[5] = '{63,15, 1'b0,  0,15, 1'b1, 14, 1'b1,  0, 15, 1'b1};
    tbl[6] = '{ 0, 0, 1'b1, -1, 0, 1'b0,  0, 1'b0,  0, 15, 1'b1};
    tbl[7] = '{15, 2, 1'b1,  8, 2, 1'b0,  0, 1'b1,  8,  2, 1'b0};
    tbl[8] = '{56, 1, 1'b1, 55, 1, 1'b0,  0, 1'b1, 55,  1, 1'b0};
    tbl[9] = '{33, 3, 1'b0, 34,12, 1'b1, 11, 1'b1, 34, 12, 1'b1};

    rst = 1'b1; req = '0; all = '0; hv = '0; thresh = 4'd0; flush = 1'b0; ack = 1'b0;
    model_reset();
    #1;
    chk("rst_vld",   64'(vld),   64'd0);
    chk("rst_id",    64'(id),    64'd0);
    chk("rst_prio",  64'(prio),  64'd0);
    chk("rst_hv",    64'(ohv),   64'd0);
    chk("rst_claim", claim,      64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: apply a static request set, let it settle, compare.
    for (int v = 0; v < 10; v++) begin
      clear_kids();
      thresh = 4'(tbl[v].th);
      set_kid(tbl[v].k0, tbl[v].p0, tbl[v].h0);
      if (tbl[v].k1 >= 0) set_kid(tbl[v].k1, tbl[v].p1, tbl[v].h1);
      ticks(4);
      chk($sformatf("tbl%0d_vld", v),  64'(vld),  64'(tbl[v].ev));
      chk($sformatf("tbl%0d_id", v),   64'(id),   64'(tbl[v].eid));
      chk($sformatf("tbl%0d_prio", v), 64'(prio), 64'(tbl[v].epr));
      chk($sformatf("tbl%0d_hv", v),   64'(ohv),  64'(tbl[v].ehv));
    end

    // Single-request latency from idle.
    clear_kids(); thresh = 4'd0;
    ticks(4);
    chk("lat_idle", 64'(vld), 64'd0);
    set_kid(12, 7, 1'b1);
    tick(); chk("lat_e0", 64'(vld), 64'd0);
    tick(); chk("lat_e1", 64'(vld), 64'd0);
    tick(); chk("lat_e2", 64'(vld), 64'd1);
    chk("lat_id", 64'(id), 64'd12);

    // Tie then preemption with vld held high.
    clear_kids();
    set_kid(9, 5, 1'b0); set_kid(3, 5, 1'b0);
    ticks(4);
    chk("tie_id", 64'(id), 64'd3);
    set_kid(40, 9, 1'b1);
    tick(); chk("pre_vld0", 64'(vld), 64'd1); chk("pre_id0", 64'(id), 64'd3);
    tick(); chk("pre_vld1", 64'(vld), 64'd1); chk("pre_id1", 64'(id), 64'd40);

    // Ack: one-cycle claim, blanking, then re-presentation.
    clear_kids();
    set_kid(20, 6, 1'b0);
    ticks(4);
    chk("ack_pre_id", 64'(id), 64'd20);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_claim", claim, one << 20);
    chk("ack_blank0", 64'(vld), 64'd0);
    tick();
    chk("ack_claim_off", claim, 64'd0);
    chk("ack_blank1", 64'(vld), 64'd0);
    wait_vld("ack_represent", 4);
    chk("ack_re_id", 64'(id), 64'd20);
    ack = 1'b1; req[20] = 1'b0; tick(); ack = 1'b0;
    chk("ack2_claim", claim, one << 20);
    for (int k = 0; k < 5; k++) begin
      tick(); chk("ack2_quiet", 64'(vld), 64'd0);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_idle_claim", claim, 64'd0);

    // Flush together with ack: no claim, vld drops, returns later.
    set_kid(20, 6, 1'b0);
    wait_vld("fl_pre", 5);
    ack = 1'b1; flush = 1'b1; tick(); ack = 1'b0; flush = 1'b0;
    chk("fl_claim", claim, 64'd0);
    chk("fl_vld0", 64'(vld), 64'd0);
    tick(); chk("fl_vld1", 64'(vld), 64'd0);
    wait_vld("fl_return", 5);

    // Reset mid-operation.
    clear_kids();
    set_kid(5, 3, 1'b0);
    ticks(4);
    chk("mr_pre_vld", 64'(vld), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_vld",   64'(vld), 64'd0);
    chk("mr_id",    64'(id),  64'd0);
    chk("mr_claim", claim,    64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick(); chk("mr_e1", 64'(vld), 64'd0);
    tick(); chk("mr_e2", 64'(vld), 64'd1);
    chk("mr_id5", 64'(id), 64'd5);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        req = '0;
        for (int i = 0; i < 64; i++) begin
          req[i] = ($urandom_range(15, 0) == 0);
          all[i*4 +: 4] = 4'($urandom_range(15, 0));
        end
        hv = {$urandom, $urandom};
        thresh = 4'($urandom_range(5, 0));
      end
      ack   = ($urandom_range(3, 0) == 0);
      flush = ($urandom_range(31, 0) == 0);
      tick();
    end
    ack = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
